// File: rtl/calc_pkg.sv
// Shared definitions for the simple-calculator datapath blocks.
package calc_pkg;

    // Divider control states; encoding 2'd3 is illegal and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } div_state_t;

    // Ceiling log2, for sizing counters from elaboration-time widths.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/div_trial_sub.sv
// Combinational (n+1)-bit trial subtractor for one restoring-division step.
module div_trial_sub #(
    parameter int n = 4
) (
    input  logic [n:0]   i_partial,
    input  logic [n-1:0] i_divisor,
    output logic [n-1:0] o_difference,
    output logic         o_non_negative
);

    logic [n:0] w_diff;

    // The sign bit leaves as the flag; when non-negative the result fits in n bits.
    always_comb begin
        w_diff         = i_partial - {1'b0, i_divisor};
        o_difference   = w_diff[n-1:0];
        o_non_negative = ~w_diff[n];
    end

endmodule

// File: rtl/seq_divider.sv
// Unsigned n-bit sequential restoring divider, one quotient bit per clock.
module seq_divider
    import calc_pkg::*;
#(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [n-1:0] dividend,
    input  logic [n-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] quotient,
    output logic [n-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CntW = clog2(n) + 1;

    div_state_t     r_state, w_state_next;
    // Working remainder: its top bit is always zero between steps, so only n bits are kept.
    logic [n-1:0]   r_rem, w_rem_next;
    // Working quotient; also holds the captured dividend for a zero divisor.
    logic [n-1:0]   r_q, w_q_next;
    logic [n-1:0]   r_dvs, w_dvs_next;
    logic [CntW-1:0] r_cnt, w_cnt_next;
    logic           r_dbz_pend, w_dbz_pend_next;
    logic           r_busy, w_busy_next;
    logic           r_done, w_done_next;
    logic [n-1:0]   r_quot, w_quot_next;
    logic [n-1:0]   r_remo, w_remo_next;
    logic           r_dbz, w_dbz_next;

    logic [n:0]     w_partial;
    logic [n-1:0]   w_diff;
    logic           w_non_neg;

    assign w_partial = {r_rem, r_q[n-1]};

    div_trial_sub #(
        .n(n)
    ) u_trial (
        .i_partial      (w_partial),
        .i_divisor      (r_dvs),
        .o_difference   (w_diff),
        .o_non_negative (w_non_neg)
    );

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_rem      <= '0;
            r_q        <= '0;
            r_dvs      <= '0;
            r_cnt      <= '0;
            r_dbz_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_quot     <= '0;
            r_remo     <= '0;
            r_dbz      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_rem      <= w_rem_next;
            r_q        <= w_q_next;
            r_dvs      <= w_dvs_next;
            r_cnt      <= w_cnt_next;
            r_dbz_pend <= w_dbz_pend_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
            r_quot     <= w_quot_next;
            r_remo     <= w_remo_next;
            r_dbz      <= w_dbz_next;
        end
    end

    // Next-state, restoring step and result capture.
    always_comb begin
        w_state_next    = r_state;
        w_rem_next      = r_rem;
        w_q_next        = r_q;
        w_dvs_next      = r_dvs;
        w_cnt_next      = r_cnt;
        w_dbz_pend_next = r_dbz_pend;
        w_busy_next     = r_busy;
        w_done_next     = 1'b0;
        w_quot_next     = r_quot;
        w_remo_next     = r_remo;
        w_dbz_next      = r_dbz;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_q_next    = dividend;
                    w_dvs_next  = divisor;
                    w_rem_next  = '0;
                    w_cnt_next  = '0;
                    w_busy_next = 1'b1;
                    if (divisor == '0) begin
                        w_dbz_pend_next = 1'b1;
                        w_state_next    = FIN;
                    end else begin
                        w_dbz_pend_next = 1'b0;
                        w_state_next    = CALC;
                    end
                end
            end
            CALC: begin
                if (w_non_neg) begin
                    w_rem_next = w_diff;
                    w_q_next   = {r_q[n-2:0], 1'b1};
                end else begin
                    w_rem_next = w_partial[n-1:0];
                    w_q_next   = {r_q[n-2:0], 1'b0};
                end
                w_cnt_next = r_cnt + CntW'(1);
                if (r_cnt == CntW'(n - 1)) begin
                    w_state_next = FIN;
                end
            end
            FIN: begin
                if (r_dbz_pend) begin
                    w_quot_next = '1;
                    w_remo_next = r_q;
                end else begin
                    w_quot_next = r_q;
                    w_remo_next = r_rem;
                end
                w_dbz_next   = r_dbz_pend;
                w_done_next  = 1'b1;
                w_busy_next  = 1'b0;
                w_state_next = IDLE;
            end
            default: begin
                w_busy_next  = 1'b0;
                w_state_next = IDLE;
            end
        endcase
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quot;
    assign remainder   = r_remo;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and exhaustive self-checking bench for seq_divider at n=4.
module tb_seq_divider;

    localparam int N = 4;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    seq_divider #(
        .n(N)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for exactly one edge.
    task automatic launch(input logic [N-1:0] dd, input logic [N-1:0] dv);
        start    = 1'b1;
        dividend = dd;
        divisor  = dv;
        step();
        start    = 1'b0;
        dividend = ~dd;
        divisor  = ~dv;
    endtask

    // Wait (bounded) for done; count cycles and busy samples seen on the way.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = busy ? 1 : 0;
        while (!done && lat < 40) begin
            step();
            lat++;
            if (!done && busy) busy_cnt++;
        end
    endtask

    // Launch one division and check results, latency, busy width and invariant.
    task automatic run_op(input string tag, input logic [N-1:0] dd, input logic [N-1:0] dv,
                          input logic [N-1:0] eq, input logic [N-1:0] er, input logic ez,
                          input int elat);
        int lat;
        int bcnt;
        launch(dd, dv);
        check_eq({tag, " pulse"}, {31'd0, done}, 32'd0);
        wait_done(lat, bcnt);
        check_eq({tag, " latency"}, lat, elat);
        check_eq({tag, " busy_cycles"}, bcnt, elat);
        check_eq({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
        check_eq({tag, " quotient"}, {28'd0, quotient}, {28'd0, eq});
        check_eq({tag, " remainder"}, {28'd0, remainder}, {28'd0, er});
        check_eq({tag, " dbz"}, {31'd0, div_by_zero}, {31'd0, ez});
        if (dv != 0) begin
            check_eq({tag, " invariant"}, 32'(quotient) * 32'(dv) + 32'(remainder), 32'(dd));
            check_eq({tag, " rem_lt_div"}, {31'd0, remainder < dv}, 32'd1);
        end
    endtask

    initial begin
        int lat;
        int bcnt;
        int done_seen;
        reset_n  = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        // 1: reset state, then 13/4.
        step();
        step();
        check_eq("rst busy", {31'd0, busy}, 32'd0);
        check_eq("rst done", {31'd0, done}, 32'd0);
        check_eq("rst quotient", {28'd0, quotient}, 32'd0);
        check_eq("rst remainder", {28'd0, remainder}, 32'd0);
        check_eq("rst dbz", {31'd0, div_by_zero}, 32'd0);
        reset_n = 1'b1;
        step();
        run_op("t1 13/4", 4'd13, 4'd4, 4'd3, 4'd1, 1'b0, 5);
        step();
        check_eq("t1 done_width", {31'd0, done}, 32'd0);
        check_eq("t1 hold_q", {28'd0, quotient}, 32'd3);

        // 2: boundaries.
        run_op("t2 15/1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 5);
        run_op("t2 3/7", 4'd3, 4'd7, 4'd0, 4'd3, 1'b0, 5);
        run_op("t2 15/15", 4'd15, 4'd15, 4'd1, 4'd0, 1'b0, 5);
        run_op("t2 0/5", 4'd0, 4'd5, 4'd0, 4'd0, 1'b0, 5);

        // 3: divide by zero.
        run_op("t3 7/0", 4'd7, 4'd0, 4'd15, 4'd7, 1'b1, 1);
        step();
        check_eq("t3 done_width", {31'd0, done}, 32'd0);
        check_eq("t3 hold_dbz", {31'd0, div_by_zero}, 32'd1);

        // 4: start while busy ignored; start in done cycle accepted.
        launch(4'd13, 4'd4);
        step();
        start    = 1'b1;
        dividend = 4'd9;
        divisor  = 4'd2;
        step();
        start    = 1'b0;
        wait_done(lat, bcnt);
        check_eq("t4 latency", lat, 3);
        check_eq("t4 quotient", {28'd0, quotient}, 32'd3);
        check_eq("t4 remainder", {28'd0, remainder}, 32'd1);
        launch(4'd9, 4'd2);
        check_eq("t4 pulse", {31'd0, done}, 32'd0);
        check_eq("t4 busy_b2b", {31'd0, busy}, 32'd1);
        check_eq("t4 hold_prev", {28'd0, quotient}, 32'd3);
        wait_done(lat, bcnt);
        check_eq("t4 b2b latency", lat, 5);
        check_eq("t4 b2b quotient", {28'd0, quotient}, 32'd4);
        check_eq("t4 b2b remainder", {28'd0, remainder}, 32'd1);

        // 5: reset mid-calculation.
        step();
        launch(4'd14, 4'd3);
        step();
        step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check_eq("t5 busy", {31'd0, busy}, 32'd0);
        check_eq("t5 done", {31'd0, done}, 32'd0);
        check_eq("t5 quotient", {28'd0, quotient}, 32'd0);
        check_eq("t5 remainder", {28'd0, remainder}, 32'd0);
        check_eq("t5 dbz", {31'd0, div_by_zero}, 32'd0);
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done) done_seen++;
        end
        check_eq("t5 no_done", done_seen, 0);
        run_op("t5 14/3", 4'd14, 4'd3, 4'd4, 4'd2, 1'b0, 5);

        // 6: exhaustive back-to-back sweep.
        for (int dd = 0; dd < 16; dd++) begin
            for (int dv = 0; dv < 16; dv++) begin
                logic [N-1:0] eq;
                logic [N-1:0] er;
                if (dv == 0) begin
                    eq = 4'd15;
                    er = 4'(dd);
                    run_op($sformatf("sweep %0d/%0d", dd, dv), 4'(dd), 4'(dv), eq, er, 1'b1, 1);
                end else begin
                    eq = 4'(dd / dv);
                    er = 4'(dd % dv);
                    run_op($sformatf("sweep %0d/%0d", dd, dv), 4'(dd), 4'(dv), eq, er, 1'b0, 5);
                end
            end
        end
        step();
        check_eq("sweep final done_width", {31'd0, done}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Unsigned n-bit sequential restoring divider: the inverse operation to the calculator's multiplier.
- Computes one quotient bit per clock using an (n+1)-bit trial subtraction.
- Sits beside the multiplier in the simple-calculator datapath and is driven by the calculator control through a start/busy/done handshake.

Parameters:
n, 4, operand width in bits (dividend, divisor, quotient, remainder); legal range 2..16

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  synchronous active-low reset, sampled on rising clk edge
start  input  1  request; accepted only when idle (busy=0)
dividend  input  n  unsigned dividend, sampled on the accept edge only
divisor  input  n  unsigned divisor, sampled on the accept edge only
busy  output  1  high while an accepted operation is in progress
done  output  1  single-cycle pulse; quotient/remainder/div_by_zero valid
quotient  output  n  unsigned quotient
remainder  output  n  unsigned remainder
div_by_zero  output  1  high with done when divisor was 0; held with results

Behaviour:
- One clock domain: clk.
- Reset is synchronous and active-low: reset_n.
- Reset (reset_n=0 at an edge):
  - state=IDLE.
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - Iteration counter and working registers cleared.
- States: IDLE, CALC, FIN.
- IDLE:
  - start=1 at edge E0 with divisor!=0 -> capture operands. Working remainder R=0 (n+1 bits), working quotient Q=dividend, counter=0, state=CALC, busy=1.
  - start=1 at E0 with divisor==0 -> state=FIN, busy=1, zero-divide flag set internally.
- CALC, each edge, one restoring step:
  - T = {R[n-1:0], Q[n-1]} - {1'b0, divisor}, in n+1 bits.
  - If T is non-negative (MSB 0): R=T, Q={Q[n-2:0],1}.
  - Else: R={R[n-1:0],Q[n-1]}, Q={Q[n-2:0],0}.
  - counter increments. After the n-th step (edge E0+n), state=FIN.
- FIN, one edge (E0+n+1 normally, E0+1 for divide-by-zero):
  - quotient=Q, remainder=R[n-1:0], div_by_zero=0, done=1, busy=0, state=IDLE.
  - Divide-by-zero case: quotient=all ones, remainder=captured dividend, div_by_zero=1.
- Latency: done is high in the cycle after edge E0+n+1, exactly n+1 cycles after the accept edge. busy is high for n+1 cycles. Divide-by-zero latency is 1 cycle.
- done: exactly one cycle wide, deasserts on the next edge.
- Output holding:
  - quotient, remainder and div_by_zero are registered and hold until the next FIN.
  - They are not cleared on a new start.
- start while busy=1: ignored; no effect on operands or state.
- start in the same cycle done=1: legal (state is IDLE). Accepted back-to-back; previous results stay on the outputs until the new FIN.
- Operand changes after the accept edge: no effect.
- reset_n=0 mid-CALC: operation abandoned. No done pulse. Outputs cleared as in reset.
- Arithmetic invariant on every non-zero-divisor done: dividend == quotient*divisor + remainder, and remainder < divisor.
- Boundaries:
  - dividend=0 -> quotient=0, remainder=0.
  - divisor=1 -> quotient=dividend.
  - dividend<divisor -> quotient=0, remainder=dividend.
  - all ones by all ones -> quotient=1, remainder=0.
- Counter width is clog2(n)+1. No wrap: the counter is reset on every accept.

Decomposition:
- Shared package (calc_pkg):
  - State encoding constants: IDLE=2'd0, CALC=2'd1, FIN=2'd2. Encoding 2'd3 is illegal and recovers to IDLE.
  - Width helper function clog2.
- One natural sub-module: div_trial_sub, the combinational (n+1)-bit trial subtractor.
  - Inputs: partial remainder, divisor.
  - Outputs: difference, non_negative flag.
  - Everything else (FSM, registers, counter) stays in seq_divider.

Test Plan:
1. n=4, reset_n low 2 cycles then high. Pulse start with dividend=13, divisor=4 -> busy for 5 cycles; done one cycle, 5 cycles after accept; quotient=3, remainder=1, div_by_zero=0.
2. n=4, dividend=15, divisor=1 -> quotient=15, remainder=0. Then dividend=3, divisor=7 -> quotient=0, remainder=3. Then dividend=15, divisor=15 -> quotient=1, remainder=0.
3. n=4, dividend=7, divisor=0 -> done 1 cycle after accept, div_by_zero=1, quotient=15, remainder=7, busy high for exactly 1 cycle.
4. Start 13/4. Assert start with 9/2 on the 2nd busy cycle (ignored) -> result 3 r1. Then start 9/2 in the done cycle (accepted) -> next done gives quotient=4, remainder=1, with no idle gap.
5. Start 14/3. Drive reset_n=0 on the 3rd busy cycle -> next cycle: busy=0, done=0, all outputs 0; no done pulse afterwards. New start 14/3 -> quotient=4, remainder=2.
6. Exhaustive sweep, n=4: all 256 dividend/divisor pairs back-to-back. The scoreboard checks the invariant, latency, and single-cycle done for each; n=8 runs 10k random pairs.
